// File: rtl/bcast_pkg.sv
// Shared widths, source encodings and the queued broadcast entry layout.
package bcast_pkg;
  localparam int MAP_W  = 6;
  localparam int DATA_W = 32;

  localparam logic SRC_EXE = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [MAP_W-1:0]  map;
    logic [DATA_W-1:0] val;
  } entry_t;
endpackage

// File: rtl/bcast_fifo.sv
// Per-source skid FIFO; ready depends only on the registered count.
// Pushes to physical tag 0 are accepted but never stored.
module bcast_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38,
  parameter int MAP_W = 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign ready     = (count < DEPTH_C);
  assign wr_en     = push && ready && !flush && (push_data[W-1 -: MAP_W] != '0);
  assign rd_en     = pop && (count != '0) && !flush;
  assign head_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/broadcast_arbiter.sv
// Merges exe and mem results onto one registered wakeup bus; mem wins ties
// unless exe has lost MAX_WAIT grants in a row. STALL/FLUSH suppress grants.
module broadcast_arbiter
  import bcast_pkg::SRC_EXE, bcast_pkg::SRC_MEM;
#(
  parameter int DEPTH    = 2,
  parameter int MAP_W    = bcast_pkg::MAP_W,
  parameter int DATA_W   = bcast_pkg::DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  input  logic                   STALL,
  input  logic                   exe_req,
  input  logic [MAP_W-1:0]       exe_map,
  input  logic [DATA_W-1:0]      exe_val,
  output logic                   exe_ready,
  input  logic                   mem_req,
  input  logic [MAP_W-1:0]       mem_map,
  input  logic [DATA_W-1:0]      mem_val,
  output logic                   mem_ready,
  output logic                   bcast_valid,
  output logic [MAP_W-1:0]       bcast_map,
  output logic [DATA_W-1:0]      bcast_val,
  output logic                   bcast_src,
  output logic [$clog2(DEPTH):0] exe_count,
  output logic [$clog2(DEPTH):0] mem_count
);
  localparam int W  = MAP_W + DATA_W;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [W-1:0]  exe_head;
  logic [W-1:0]  mem_head;
  logic          exe_ne;
  logic          mem_ne;
  logic          active;
  logic          gnt_exe;
  logic          gnt_mem;
  logic [WW-1:0] exe_wait;

  bcast_fifo #(.DEPTH(DEPTH), .W(W), .MAP_W(MAP_W)) u_exe_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (FLUSH),
    .push      (exe_req),
    .push_data ({exe_map, exe_val}),
    .pop       (gnt_exe),
    .head_data (exe_head),
    .count     (exe_count),
    .ready     (exe_ready)
  );

  bcast_fifo #(.DEPTH(DEPTH), .W(W), .MAP_W(MAP_W)) u_mem_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (FLUSH),
    .push      (mem_req),
    .push_data ({mem_map, mem_val}),
    .pop       (gnt_mem),
    .head_data (mem_head),
    .count     (mem_count),
    .ready     (mem_ready)
  );

  // Grants use only registered FIFO state, so no input reaches an output combinationally.
  always_comb begin
    exe_ne  = (exe_count != '0);
    mem_ne  = (mem_count != '0);
    active  = !STALL && !FLUSH;
    gnt_exe = active && exe_ne && (!mem_ne || (exe_wait == WAIT_MAX));
    gnt_mem = active && mem_ne && !gnt_exe;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exe_wait <= '0;
    end else if (FLUSH) begin
      exe_wait <= '0;
    end else if (!STALL) begin
      if (gnt_exe || !exe_ne) begin
        exe_wait <= '0;
      end else if (gnt_mem && (exe_wait != WAIT_MAX)) begin
        exe_wait <= exe_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bcast_valid <= 1'b0;
      bcast_map   <= '0;
      bcast_val   <= '0;
      bcast_src   <= 1'b0;
    end else if (gnt_exe) begin
      bcast_valid <= 1'b1;
      bcast_map   <= exe_head[W-1 -: MAP_W];
      bcast_val   <= exe_head[DATA_W-1:0];
      bcast_src   <= SRC_EXE;
    end else if (gnt_mem) begin
      bcast_valid <= 1'b1;
      bcast_map   <= mem_head[W-1 -: MAP_W];
      bcast_val   <= mem_head[DATA_W-1:0];
      bcast_src   <= SRC_MEM;
    end else begin
      bcast_valid <= 1'b0;
    end
  end
endmodule

// File: doc/broadcast_arbiter.md
# broadcast_arbiter

Arbitrates the execute-stage and memory-stage result broadcasts onto the single wakeup/forwarding bus that feeds the issue queue's operand-capture logic and the physical register file. Each source gets a small skid FIFO, so a source never drops a result when the bus is busy. Memory results have default priority. A starvation counter guarantees execute-stage progress. The block sits between the exe/mem stages and Issue, replacing their direct broadcast wiring.

## Interface
- DEPTH, 2: entries per source FIFO (power of two, ≥2)
- MAP_W, 6: physical register tag width
- DATA_W, 32: broadcast value width
- MAX_WAIT, 3: consecutive lost grants after which exe is forced to win

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous clear (misprediction recovery)
- STALL  in  1  pipeline freeze
- exe_req  in  1  exe result valid this cycle
- exe_map  in  MAP_W  exe destination physical tag
- exe_val  in  DATA_W  exe result value
- exe_ready  out  1  exe FIFO can accept (count < DEPTH)
- mem_req, mem_map, mem_val, mem_ready: same as exe_*, memory stage
- bcast_valid  out  1  broadcast valid (registered)
- bcast_map  out  MAP_W  broadcast tag (registered)
- bcast_val  out  DATA_W  broadcast value (registered)
- bcast_src  out  1  0 = exe, 1 = mem (registered)
- exe_count, mem_count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: at posedge, if src_req && src_ready, push {map,val} to that source's FIFO. Exception: if map==0, the push is accepted but discarded, because p0 is hardwired and must never be broadcast.
- src_ready is computed from registered count only. It does not look at a same-cycle pop, so a full FIFO refuses a push even while it is popping.
- Arbitration: evaluated on pre-edge FIFO state, once per posedge when !STALL && !FLUSH.
  - Both FIFOs empty: bcast_valid <= 0.
  - Only one FIFO non-empty: grant that source.
  - Both non-empty: grant mem, unless exe_wait == MAX_WAIT, in which case grant exe.
- Grant: pop the head of the granted FIFO; bcast_* <= head fields, bcast_src <= source, bcast_valid <= 1.
- Starvation counter exe_wait, width clog2(MAX_WAIT+1):
  - Increments (saturating at MAX_WAIT) when exe is non-empty and mem is granted.
  - Clears when exe is granted or the exe FIFO is empty.
  - Held during STALL.
- STALL: Issue ignores broadcasts while stalled, so during STALL:
  - bcast_valid <= 0 and no pops occur.
  - Pushes are still accepted.
  - Nothing is lost; stored results drain after STALL falls.
- FLUSH (has priority over STALL and push): FIFOs emptied (pointers and counts to 0), bcast_valid <= 0, exe_wait <= 0. A push presented in the same cycle is dropped.
- FIFO pointers wrap modulo DEPTH. Push and pop on the same FIFO in the same edge leave count unchanged.

## Timing
- Reset (async, immediate): bcast_valid, bcast_map, bcast_val, bcast_src = 0; counts = 0; exe_wait = 0; exe_ready = mem_ready = 1.
- Latency: a result pushed at edge N is broadcast at the earliest from edge N+1. bcast_valid is then high for exactly one cycle per entry.
- Throughput: one broadcast per cycle total.
- Sustained dual-source load: the exe source gets at least one grant every MAX_WAIT+1 cycles.
- No combinational path from any *_req / *_map / *_val input to any output.
- RESET deasserted mid-stream: the FIFO contents are lost. Requesters must also be in reset, so no recovery handshake exists.

## Structure
- Shared package `bcast_pkg`: MAP_W, DATA_W, SRC_EXE=1'b0, SRC_MEM=1'b1, and the packed {map,val} entry typedef.
- Sub-module `bcast_fifo`, instantiated twice, one per source.
  - Contains the DEPTH-entry register array, read/write pointers, count, full/empty and the map==0 discard.
  - Ports: push, push_data, pop, head_data, count, ready.
- Top level holds the grant logic, exe_wait and the output registers.

## Test plan
- Exe-only traffic: exe_req at edge 0 with map=5, val=0xDEAD → at edge 1 bcast_valid=1, map=5, val=0xDEAD, src=0; at edge 2 bcast_valid=0.
- Simultaneous push: exe map=7 and mem map=9 at edge 0 → mem (map 9) broadcast at edge 1, exe (map 7) at edge 2.
- Starvation: both sources push every cycle with MAX_WAIT=3 → steady-state grant pattern mem,mem,mem,exe repeating. Pushes back-pressure whenever the FIFO is full (src_ready=0 until a pop frees an entry), and no accepted entry is lost or reordered within its source.
- Full FIFO: 3 exe pushes in consecutive cycles while mem occupies the bus and DEPTH=2 → exe_ready=0 after 2 entries, third push refused; first entry has drained correctly once mem stops.
- STALL: 2 entries queued, STALL high for 3 cycles → bcast_valid=0 throughout and counts stay at 2; after STALL falls, both entries broadcast on consecutive cycles.
- FLUSH with map=0: exe push of map=0 yields no broadcast and exe_count stays 0. FLUSH with 2 queued entries plus a same-cycle push → counts 0 and bcast_valid=0 next cycle. Async RESET mid-broadcast → outputs 0 immediately, without waiting for a clock edge.
